rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Produces a registered one-hot grant together with its 3-bit binary index, using the same bit-to-index mapping as the 8x3 encoder (bit0 -> 3'b000 … bit7 -> 3'b111).
- The index drives downstream mux selects, so it must always be a legal encoding of the one-hot grant.
- Grant tenure ends on requester release or on a hold-time limit.

---
 rtl/rr_arbiter8_if.sv | 27 ++
 rtl/rr_arbiter8.sv | 89 ++++++++
 tb/tb_rr_arbiter8.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       en;
  logic [7:0] grant;
  logic [2:0] grant_code;
  logic       grant_valid;
  logic       expired;

  modport master (
    output req,
    output en,
    input  grant,
    input  grant_code,
    input  grant_valid,
    input  expired
  );

  modport slave (
    input  req,
    input  en,
    output grant,
    output grant_code,
    output grant_valid,
    output expired
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with registered one-hot grant and hold-time limit
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave arb
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [7:0]       r_grant;
  logic [2:0]       r_code;
  logic             r_valid;
  logic             r_expired;

  logic             w_hit;
  logic [2:0]       w_win;
  logic [2:0]       w_cand;
  logic             w_last_cycle;

  assign w_last_cycle = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

  // First requester at or after r_ptr, wrapping 7 -> 0.
  always_comb begin
    w_hit  = 1'b0;
    w_win  = 3'd0;
    w_cand = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w_cand = r_ptr + 3'(k);
      if (!w_hit && arb.req[w_cand]) begin
        w_hit = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 3'd0;
      r_hold_cnt <= '0;
      r_grant    <= 8'h00;
      r_code     <= 3'd0;
      r_valid    <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (arb.en && w_hit) begin
            r_state    <= ST_GRANT;
            r_grant    <= 8'd1 << w_win;
            r_code     <= w_win;
            r_valid    <= 1'b1;
            r_ptr      <= w_win + 3'd1;
            r_hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          // Grant code and one-hot are always cleared together so the mux select stays legal.
          if (!arb.req[r_code] || w_last_cycle) begin
            r_state    <= ST_IDLE;
            r_grant    <= 8'h00;
            r_code     <= 3'd0;
            r_valid    <= 1'b0;
            r_hold_cnt <= '0;
            r_expired  <= arb.req[r_code];
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign arb.grant       = r_grant;
  assign arb.grant_code  = r_code;
  assign arb.grant_valid = r_valid;
  assign arb.expired     = r_expired;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8
module tb_rr_arbiter8;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   run_len;

  rr_arbiter8_if arb_if ();

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: who holds the resource, for how many visible cycles, and the rotation start.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_held   = 0;
  bit m_exp    = 1'b0;

  function automatic int pick_winner(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_holder <= -1;
      m_ptr    <= 0;
      m_held   <= 0;
      m_exp    <= 1'b0;
    end else if (m_holder < 0) begin
      m_exp <= 1'b0;
      if (arb_if.en && arb_if.req != 8'h00) begin
        m_holder <= pick_winner(arb_if.req, m_ptr);
        m_ptr    <= (pick_winner(arb_if.req, m_ptr) + 1) % 8;
        m_held   <= 1;
      end
    end else if (!arb_if.req[m_holder]) begin
      m_holder <= -1;
      m_exp    <= 1'b0;
    end else if (m_held == MAX_HOLD) begin
      m_holder <= -1;
      m_exp    <= 1'b1;
    end else begin
      m_held <= m_held + 1;
      m_exp  <= 1'b0;
    end
  end

  function automatic logic [2:0] enc(input logic [7:0] g);
    for (int i = 0; i < 8; i++) if (g[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic check_all();
    logic [7:0] e_grant;
    logic [2:0] e_code;
    e_grant = (m_holder < 0) ? 8'h00 : 8'(1 << m_holder);
    e_code  = (m_holder < 0) ? 3'd0 : 3'(m_holder);
    check("model_grant", 32'(arb_if.grant), 32'(e_grant));
    check("model_code", 32'(arb_if.grant_code), 32'(e_code));
    check("model_valid", 32'(arb_if.grant_valid), 32'(m_holder >= 0));
    check("model_expired", 32'(arb_if.expired), 32'(m_exp));
    check("inv_onehot", 32'($onehot0(arb_if.grant)), 32'd1);
    check("inv_code", 32'(arb_if.grant_code), 32'(enc(arb_if.grant)));
    check("inv_valid", 32'(arb_if.grant_valid), 32'(arb_if.grant != 8'h00));
    run_len = arb_if.grant_valid ? run_len + 1 : 0;
    check("inv_tenure", 32'(run_len <= MAX_HOLD), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic expect_out(input string name, input logic [7:0] g, input logic [2:0] c,
                            input logic v, input logic e);
    check({name, "_grant"}, 32'(arb_if.grant), 32'(g));
    check({name, "_code"}, 32'(arb_if.grant_code), 32'(c));
    check({name, "_valid"}, 32'(arb_if.grant_valid), 32'(v));
    check({name, "_expired"}, 32'(arb_if.expired), 32'(e));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arb_if.req = 8'h00;
    arb_if.en  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] req;
    logic       en;
    logic [7:0] grant;
    logic [2:0] code;
    logic       valid;
    logic       expired;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] r, input logic e, input logic [7:0] g,
                         input logic [2:0] c, input logic v, input logic x);
    vecs.push_back('{req: r, en: e, grant: g, code: c, valid: v, expired: x});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    run_len = 0;
    rst = 1'b1;
    arb_if.req = 8'h00;
    arb_if.en  = 1'b0;

    // Rotation with one-cycle drop after two granted cycles, then wrap/skip.
    for (int i = 0; i < 8; i++) begin
      add_vec(8'hFF, 1'b1, 8'(1 << i), 3'(i), 1'b1, 1'b0);
      add_vec(8'hFF, 1'b1, 8'(1 << i), 3'(i), 1'b1, 1'b0);
      add_vec(8'hFF & ~8'(1 << i), 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    end
    add_vec(8'hFF, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    add_vec(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    add_vec(8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0);
    add_vec(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    add_vec(8'h09, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    add_vec(8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    add_vec(8'h09, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0);
    add_vec(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Reset values, first grant, asynchronous reset mid-tenure.
    @(negedge clk);
    expect_out("rst_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    arb_if.req = 8'hFF;
    arb_if.en  = 1'b1;
    tick();
    expect_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    tick();
    expect_out("post_rst_grant", 8'h01, 3'd0, 1'b1, 1'b0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      arb_if.req = vecs[i].req;
      arb_if.en  = vecs[i].en;
      tick();
      expect_out($sformatf("row%0d", i), vecs[i].grant, vecs[i].code, vecs[i].valid,
                 vecs[i].expired);
    end

    // Hold-time limit with a constant request.
    arb_if.req = 8'h04;
    arb_if.en  = 1'b1;
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      expect_out($sformatf("hold%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    tick();
    expect_out("expire", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    expect_out("regrant", 8'h04, 3'd2, 1'b1, 1'b0);
    arb_if.req = 8'h00;
    tick();
    expect_out("drop_after_regrant", 8'h00, 3'd0, 1'b0, 1'b0);

    // Enable gating and no preemption.
    arb_if.req = 8'h10;
    arb_if.en  = 1'b0;
    tick();
    tick();
    expect_out("en_off", 8'h00, 3'd0, 1'b0, 1'b0);
    arb_if.en = 1'b1;
    tick();
    expect_out("en_on", 8'h10, 3'd4, 1'b1, 1'b0);
    arb_if.en  = 1'b0;
    arb_if.req = 8'h12;
    tick();
    tick();
    expect_out("no_preempt", 8'h10, 3'd4, 1'b1, 1'b0);
    arb_if.req = 8'h02;
    tick();
    expect_out("release4", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    expect_out("wait_en", 8'h00, 3'd0, 1'b0, 1'b0);
    arb_if.en = 1'b1;
    tick();
    expect_out("grant1", 8'h02, 3'd1, 1'b1, 1'b0);

    // Random traffic against the reference model.
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      case ($urandom_range(0, 3))
        0: arb_if.req = 8'($urandom);
        1: arb_if.req = 8'(1 << $urandom_range(0, 7));
        2: arb_if.req = arb_if.req;
        default: arb_if.req = $urandom_range(0, 1) ? 8'hFF : 8'h00;
      endcase
      arb_if.en = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
